reg_file: RTL and testbench

- Architectural register file of the five-stage pipeline; the receiving end of the write-back interface.
- Accepts the write-back triple (`RegWrite`, `WriteReg`, `WriteData`) on one write port.
- Serves two combinational read ports to the decode stage.
- After reset, a sequencer clears every register before `Ready` releases the pipeline.
- Storage is a plain memory array without per-register reset, so it maps onto FPGA distributed RAM.

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_file_init_seq.sv | 39 +++
 rtl/reg_file.sv | 77 +++++++
 tb/tb_reg_file.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_pkg : shared defaults and FSM encoding for reg_file          |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package reg_file_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_ADDR_W   = 5;
    localparam int DEFAULT_NUM_REGS = 2 ** DEFAULT_ADDR_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int REG_ZERO = 0;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_init_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_init_seq : INIT/RUN sequencer walking a clear counter        |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module reg_file_init_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              Ready
);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_count <= '0;
        end else if (r_state == ST_INIT) begin
            r_count <= r_count + 1'b1;
            // Last register is cleared on the same edge that enters RUN
            if (r_count == {ADDR_W{1'b1}}) begin
                r_state <= ST_RUN;
            end
        end
    end

    assign init_we   = (r_state == ST_INIT);
    assign init_addr = r_count;
    assign Ready     = (r_state == ST_RUN);

endmodule : reg_file_init_seq
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file : 2R/1W architectural register file with clear-on-reset      |
// | Option   : REG_FILE_BYPASS_EN enables same-cycle write-to-read bypass |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_file
    import reg_file_pkg::*;
#(
    parameter int                DATA_W     = DEFAULT_DATA_W,
    parameter int                ADDR_W     = DEFAULT_ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Ready
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] REG0 = ADDR_W'(REG_ZERO);

    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_addr;
    logic              w_user_we;

    // No reset on the array so it stays mappable onto distributed RAM
    logic [DATA_W-1:0] r_mem [NUM_REGS];

    reg_file_init_seq #(
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_we   (w_init_we),
        .init_addr (w_init_addr),
        .Ready     (Ready)
    );

    assign w_user_we = Ready && RegWrite && (WriteReg != REG0);

    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= INIT_VALUE;
        end else if (w_user_we) begin
            r_mem[WriteReg] <= WriteData;
        end
    end

    always_comb begin
        ReadData1 = r_mem[ReadReg1];
        ReadData2 = r_mem[ReadReg2];
`ifdef REG_FILE_BYPASS_EN
        if (w_user_we && (ReadReg1 == WriteReg)) begin
            ReadData1 = WriteData;
        end
        if (w_user_we && (ReadReg2 == WriteReg)) begin
            ReadData2 = WriteData;
        end
`endif
        // Register 0 and the clear phase override whatever the array holds
        if (!Ready || (ReadReg1 == REG0)) begin
            ReadData1 = '0;
        end
        if (!Ready || (ReadReg2 == REG0)) begin
            ReadData2 = '0;
        end
    end

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_file : scoreboard-driven bench for reg_file                    |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        Ready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .Ready     (Ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int edges;
        rst_n    = 1'b0;
        RegWrite = 1'b0;
        ReadReg1 = 5'd5;
        ReadReg2 = 5'd0;
        repeat (3) step();
        checks++;
        if (Ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %b expected 0", Ready);
        end
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (ReadData1 !== e) begin
            errors++;
            $display("FAIL reset_read_zero: got %h expected %h", ReadData1, e);
        end
        rst_n = 1'b1;
        edges = 0;
        while (Ready !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
        checks++;
        if (edges != 32) begin
            errors++;
            $display("FAIL reset_clear_len: got %0d edges expected 32", edges);
        end
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (ReadData1 !== e) begin
                errors++;
                $display("FAIL cleared_rd1 r%0d: got %h expected %h", i, ReadData1, e);
            end
            e = exp_q.pop_front();
            checks++;
            if (ReadData2 !== e) begin
                errors++;
                $display("FAIL cleared_rd2 r%0d: got %h expected %h", 31 - i, ReadData2, e);
            end
        end
    endtask

    task automatic test_basic();
        RegWrite  = 1'b1;
        WriteReg  = 5'd5;
        WriteData = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        step();
        RegWrite = 1'b0;
        ReadReg1 = 5'd5;
        ReadReg2 = 5'd5;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (ReadData1 !== e) begin
            errors++;
            $display("FAIL basic_rd1: got %h expected %h", ReadData1, e);
        end
        checks++;
        if (ReadData2 !== e) begin
            errors++;
            $display("FAIL basic_rd2: got %h expected %h", ReadData2, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  addrs [5];
        logic [31:0] vals  [5];
        addrs = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd31};
        vals  = '{32'hCAFE0001, 32'h0BADF00D, 32'hFFFFFFFF, 32'h00000000, 32'h80000001};
        for (int k = 0; k < 5; k++) begin
            RegWrite  = 1'b1;
            WriteReg  = addrs[k];
            WriteData = vals[k];
            exp_q.push_back(vals[k]);
            step();
        end
        RegWrite = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ReadReg1 = addrs[k];
            ReadReg2 = addrs[k];
            #1;
            e = exp_q.pop_front();
            checks++;
            if (ReadData1 !== e || ReadData2 !== e) begin
                errors++;
                $display("FAIL b2b r%0d: got %h/%h expected %h", addrs[k], ReadData1, ReadData2, e);
            end
        end
    endtask

    task automatic test_reg0();
        ReadReg1  = 5'd0;
        ReadReg2  = 5'd0;
        RegWrite  = 1'b1;
        WriteReg  = 5'd0;
        WriteData = 32'h12345678;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (ReadData1 !== e || ReadData2 !== e) begin
            errors++;
            $display("FAIL reg0_before: got %h/%h expected %h", ReadData1, ReadData2, e);
        end
        step();
        RegWrite = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (ReadData1 !== e || ReadData2 !== e) begin
            errors++;
            $display("FAIL reg0_after: got %h/%h expected %h", ReadData1, ReadData2, e);
        end
    endtask

    task automatic test_bypass();
        RegWrite  = 1'b1;
        WriteReg  = 5'd7;
        WriteData = 32'h1;
        step();
        WriteData = 32'hA5A5A5A5;
        ReadReg1  = 5'd7;
        ReadReg2  = 5'd5;
`ifdef REG_FILE_BYPASS_EN
        exp_q.push_back(32'hA5A5A5A5);
`else
        exp_q.push_back(32'h1);
`endif
        #1;
        e = exp_q.pop_front();
        checks++;
        if (ReadData1 !== e) begin
            errors++;
            $display("FAIL same_cycle_r7: got %h expected %h", ReadData1, e);
        end
        exp_q.push_back(32'hA5A5A5A5);
        step();
        RegWrite = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (ReadData1 !== e) begin
            errors++;
            $display("FAIL after_write_r7: got %h expected %h", ReadData1, e);
        end
    endtask

    task automatic test_reset_mid();
        int edges;
        RegWrite  = 1'b1;
        WriteReg  = 5'd9;
        WriteData = 32'h55;
        exp_q.push_back(32'h55);
        step();
        RegWrite = 1'b0;
        ReadReg1 = 5'd9;
        ReadReg2 = 5'd10;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (ReadData1 !== e) begin
            errors++;
            $display("FAIL mid_pre_r9: got %h expected %h", ReadData1, e);
        end
        RegWrite  = 1'b1;
        WriteReg  = 5'd10;
        WriteData = 32'h77;
        rst_n     = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        checks++;
        if (Ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_ready: got %b expected 0", Ready);
        end
        e = exp_q.pop_front();
        checks++;
        if (ReadData1 !== e) begin
            errors++;
            $display("FAIL init_read_zero: got %h expected %h", ReadData1, e);
        end
        step();
        rst_n    = 1'b1;
        RegWrite = 1'b0;
        edges    = 0;
        while (Ready !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
        checks++;
        if (edges != 32) begin
            errors++;
            $display("FAIL mid_clear_len: got %0d edges expected 32", edges);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (ReadData1 !== e) begin
            errors++;
            $display("FAIL mid_post_r9: got %h expected %h", ReadData1, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (ReadData2 !== e) begin
            errors++;
            $display("FAIL mid_lost_r10: got %h expected %h", ReadData2, e);
        end
    endtask

    task automatic test_init_write();
        int edges;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        edges     = 1;
        RegWrite  = 1'b1;
        WriteReg  = 5'd3;
        WriteData = 32'hFFFFFFFF;
        repeat (5) begin
            step();
            edges++;
        end
        RegWrite = 1'b0;
        while (Ready !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
        checks++;
        if (edges != 32) begin
            errors++;
            $display("FAIL init_write_clear_len: got %0d edges expected 32", edges);
        end
        ReadReg1 = 5'd3;
        ReadReg2 = 5'd3;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (ReadData1 !== e || ReadData2 !== e) begin
            errors++;
            $display("FAIL init_write_r3: got %h/%h expected %h", ReadData1, ReadData2, e);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = 5'd0;
        WriteData = 32'h0;
        ReadReg1  = 5'd0;
        ReadReg2  = 5'd0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_reg0();
        test_bypass();
        test_reset_mid();
        test_init_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire
